// File: rtl/spi_master_gen2.sv
// SPI master: one DATA_WIDTH frame per accepted start, all CPOL/CPHA modes, MSB/LSB first, decoded active-low chip selects.
// Latency: done pulses (2*DATA_WIDTH+2)*(clk_div+1)+1 clk after start (one SETUP slot fewer when re-using a held CS).
// Backpressure: start is accepted only in IDLE; a start while busy is dropped, so the caller must wait for done.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start                       one-cycle frame request (ignored while busy)
//   cpol, cpha, lsb_first       SPI mode and bit order, latched at start
//   cs_hold, cs_release         keep CS low after the frame / drop a held CS while idle
//   cs_sel, clk_div, data_in    target select, SCK half-period minus one, transmit frame
//   miso / sck, mosi, cs_n      serial interface
//   busy, done, data_out        status and last received frame
module spi_master_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8,
  parameter int NUM_CS     = 4,
  parameter int CS_WIDTH   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  cs_hold,
  input  logic                  cs_release,
  input  logic [CS_WIDTH-1:0]   cs_sel,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  miso,
  output logic                  sck,
  output logic                  mosi,
  output logic [NUM_CS-1:0]     cs_n,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int EDGES = 2 * DATA_WIDTH;
  localparam int EW    = $clog2(EDGES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, TRAIL} state_t;
  state_t state, state_nxt;

  // Per-frame configuration, frozen at start acceptance
  logic                  cpol_q, cpha_q, lsb_q, hold_q;
  logic [CS_WIDTH-1:0]   sel_q;
  logic [DIV_WIDTH-1:0]  div_q;

  logic [DIV_WIDTH-1:0]  div_cnt;
  logic [EW-1:0]         edge_cnt;     // SCK edges already produced this frame
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr;
  logic                  held_vld;     // a CS is still low from a cs_hold frame
  logic [CS_WIDTH-1:0]   held_idx;

  logic                  wrap, last_edge, odd_edge, tx_edge, do_sample, do_shift, reuse_cs;
  logic [NUM_CS-1:0]     sel_dec;

  assign wrap      = (div_cnt == div_q);
  assign last_edge = (edge_cnt == EW'(EDGES - 1));
  assign odd_edge  = ~edge_cnt[0];     // the edge about to happen is 1,3,5,...
  assign tx_edge   = (state == TRANSFER) && wrap;

  // CPHA=0: sample on odd edges, shift on even ones except the very last.
  // CPHA=1: shift on odd edges except the first (bit 0 is already on mosi), sample on even ones.
  assign do_sample = tx_edge && (cpha_q ? !odd_edge : odd_edge);
  assign do_shift  = tx_edge && (cpha_q ? (odd_edge && (edge_cnt != '0)) : (!odd_edge && !last_edge));

  // A simultaneous cs_release forces the full release/SETUP path even for the same index.
  assign reuse_cs = held_vld && !cs_release && (cs_sel == held_idx);

  assign mosi = lsb_q ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
  assign busy = (state != IDLE);

  // Out-of-range selects decode to all-ones, so no chip select is driven.
  always_comb begin
    sel_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_WIDTH'(i)) sel_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start)             state_nxt = reuse_cs ? TRANSFER : SETUP;
      SETUP:    if (wrap)              state_nxt = TRANSFER;
      TRANSFER: if (wrap && last_edge) state_nxt = TRAIL;
      TRAIL:    if (wrap)              state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck      <= 1'b0;
      cs_n     <= '1;
      done     <= 1'b0;
      data_out <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      hold_q   <= 1'b0;
      sel_q    <= '0;
      div_q    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      held_vld <= 1'b0;
      held_idx <= '0;
    end else begin
      done <= 1'b0;

      // Each wrap is one SCK edge or timing slot; every state starts a fresh slot.
      if (state == IDLE || state_nxt != state || wrap) div_cnt <= '0;
      else                                              div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE: begin
          sck      <= cpol;
          edge_cnt <= '0;
          if (start) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            hold_q <= cs_hold;
            sel_q  <= cs_sel;
            div_q  <= clk_div;
            tx_sr  <= data_in;
            rx_sr  <= '0;
            // One register update drops the old CS and drives the new one,
            // so two selects can never be low together.
            if (!reuse_cs) begin
              cs_n     <= sel_dec;
              held_vld <= 1'b0;
            end
          end else if (cs_release) begin
            cs_n     <= '1;
            held_vld <= 1'b0;
          end
        end
        SETUP: sck <= cpol_q;
        TRANSFER: begin
          if (wrap) begin
            sck      <= ~sck;
            edge_cnt <= edge_cnt + 1'b1;
          end
          // Receive bits enter opposite the transmit end to land in natural order.
          if (do_sample) rx_sr <= lsb_q ? {miso, rx_sr[DATA_WIDTH-1:1]} : {rx_sr[DATA_WIDTH-2:0], miso};
          if (do_shift)  tx_sr <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
        end
        TRAIL: begin
          sck <= cpol_q;
          if (wrap) begin
            done     <= 1'b1;
            data_out <= rx_sr;
            if (hold_q) begin
              held_vld <= (cs_n != '1);
              held_idx <= sel_q;
            end else begin
              cs_n     <= '1;
              held_vld <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen2.sv
// Directed bench for spi_master_gen2: table of single frames against an SPI slave model, plus held-CS, busy/out-of-range and reset sequences.
// Latency: each frame is timed in clk cycles from the start pulse to done.
// Backpressure: frames are issued only after the previous done; one deliberate start-while-busy.
module tb_spi_master_gen2;

  logic       clk = 1'b0;
  logic       rst, start, cpol, cpha, lsb_first, cs_hold, cs_release, miso;
  logic [2:0] cs_sel;
  logic [7:0] clk_div, data_in, data_out;
  logic       sck, mosi, busy, done;
  logic [3:0] cs_n;

  always #5 clk = ~clk;

  spi_master_gen2 #(.DATA_WIDTH(8), .DIV_WIDTH(8), .NUM_CS(4), .CS_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .cs_hold(cs_hold), .cs_release(cs_release), .cs_sel(cs_sel), .clk_div(clk_div),
    .data_in(data_in), .miso(miso), .sck(sck), .mosi(mosi), .cs_n(cs_n), .busy(busy),
    .done(done), .data_out(data_out)
  );

  // ---------------- SPI slave model ----------------
  logic       loop = 1'b0;
  logic       slv_arm = 1'b0, arm_seen = 1'b0, slv_en = 1'b0;
  logic       slv_cpha = 1'b0, slv_lsb = 1'b0;
  logic [7:0] slv_dat = 8'h00, slv_tx = 8'h00, slv_rx = 8'h00;
  int         slv_edges = 0;
  logic       slv_miso;

  assign slv_miso = slv_lsb ? slv_tx[0] : slv_tx[7];
  assign miso     = loop ? mosi : slv_miso;

  always @(sck or slv_arm) begin
    if (slv_arm !== arm_seen) begin
      arm_seen  = slv_arm;
      slv_tx    = slv_dat;
      slv_rx    = 8'h00;
      slv_edges = 0;
    end else if (slv_en) begin
      slv_edges++;
      if ((slv_edges % 2 == 1) != slv_cpha)
        slv_rx = slv_lsb ? {mosi, slv_rx[7:1]} : {slv_rx[6:0], mosi};
      else if (slv_edges > 1 && slv_edges < 16)
        slv_tx = slv_lsb ? (slv_tx >> 1) : (slv_tx << 1);
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
  endtask

  typedef struct {
    logic       cpol, cpha, lsb, hold, loop;
    logic [7:0] div;
    logic [2:0] sel;
    logic [7:0] din, slv_dat, exp_dout, exp_srx;
    logic [3:0] exp_cs;
  } vec_t;

  function automatic vec_t mk(input logic cp, input logic ph, input logic lsb, input logic hold,
                              input logic lp, input logic [7:0] div, input logic [2:0] sel,
                              input logic [7:0] din, input logic [7:0] sd, input logic [7:0] edout,
                              input logic [7:0] esrx, input logic [3:0] ecs);
    vec_t v;
    v.cpol = cp; v.cpha = ph; v.lsb = lsb; v.hold = hold; v.loop = lp; v.div = div; v.sel = sel;
    v.din = din; v.slv_dat = sd; v.exp_dout = edout; v.exp_srx = esrx; v.exp_cs = ecs;
    return v;
  endfunction

  task automatic setup_inputs(input vec_t v);
    @(negedge clk);
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; cs_hold = v.hold; cs_sel = v.sel;
    clk_div = v.div; data_in = v.din; loop = v.loop;
    slv_dat = v.slv_dat; slv_cpha = v.cpha; slv_lsb = v.lsb;
    repeat (2) @(negedge clk);
  endtask

  // Runs one frame; exp_len counts clk cycles from the start pulse to the done cycle.
  task automatic run_frame(input string tag, input vec_t v, input int exp_len);
    int n, edges;
    logic prev, first_mosi;
    logic [3:0] cs_mid;
    setup_inputs(v);
    chk(tag, "idle sck before", 32'(sck), 32'(v.cpol));
    slv_arm = ~slv_arm;
    slv_en  = 1'b1;
    prev = sck; n = 0; edges = 0; first_mosi = 1'b0; cs_mid = 4'h0;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) begin first_mosi = mosi; cs_mid = cs_n; end
      if (sck !== prev) edges++;
      prev = sck;
    end while (done !== 1'b1 && n < 2000);
    chk(tag, "frame length", 32'(n), 32'(exp_len));
    chk(tag, "sck edges", 32'(edges), 32'd16);
    chk(tag, "first mosi", 32'(first_mosi), 32'(v.lsb ? v.din[0] : v.din[7]));
    chk(tag, "cs_n in frame", 32'(cs_mid), 32'(v.exp_cs));
    chk(tag, "data_out", 32'(data_out), 32'(v.exp_dout));
    chk(tag, "slave rx", 32'(slv_rx), 32'(v.exp_srx));
    chk(tag, "busy at done", 32'(busy), 32'd0);
    @(negedge clk);
    slv_en = 1'b0;
    chk(tag, "done one cycle", 32'(done), 32'd0);
    chk(tag, "idle sck after", 32'(sck), 32'(v.cpol));
    chk(tag, "cs_n after", 32'(cs_n), 32'(v.hold ? v.exp_cs : 4'hF));
  endtask

  vec_t vecs[6];
  vec_t hv;
  int   lens[6];

  initial begin
    int n, dones, cs_bad, edges;
    logic prev;

    //            cpol ph  lsb hold loop div    sel   din    slave  dout   srx    cs_n
    vecs[0] = mk(0,   0,  0,  0,   1,   8'd1, 3'd2, 8'hA5, 8'h00, 8'hA5, 8'hA5, 4'b1011); lens[0] = 37;
    vecs[1] = mk(0,   1,  0,  0,   0,   8'd1, 3'd0, 8'hC3, 8'h3C, 8'h3C, 8'hC3, 4'b1110); lens[1] = 37;
    vecs[2] = mk(1,   0,  0,  0,   0,   8'd1, 3'd1, 8'hC3, 8'h3C, 8'h3C, 8'hC3, 4'b1101); lens[2] = 37;
    vecs[3] = mk(1,   1,  0,  0,   0,   8'd1, 3'd3, 8'hC3, 8'h3C, 8'h3C, 8'hC3, 4'b0111); lens[3] = 37;
    vecs[4] = mk(0,   0,  1,  0,   0,   8'd0, 3'd2, 8'h01, 8'h80, 8'h80, 8'h01, 4'b1011); lens[4] = 19;
    vecs[5] = mk(0,   0,  0,  0,   0,   8'd2, 3'd0, 8'h5A, 8'h96, 8'h96, 8'h5A, 4'b1110); lens[5] = 55;

    rst = 1'b1; start = 1'b0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; cs_hold = 1'b0;
    cs_release = 1'b0; cs_sel = 3'd0; clk_div = 8'd0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset", "sck", 32'(sck), 32'd0);
    chk("reset", "cs_n", 32'(cs_n), 32'hF);
    chk("reset", "busy", 32'(busy), 32'd0);
    chk("reset", "done", 32'(done), 32'd0);
    chk("reset", "data_out", 32'(data_out), 32'd0);
    chk("reset", "mosi", 32'(mosi), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle", "sck follows cpol", 32'(sck), 32'd1);

    for (int i = 0; i < 6; i++) run_frame($sformatf("vec%0d", i), vecs[i], lens[i]);

    // Held CS: the second frame on the same select skips SETUP, then cs_release drops it.
    hv = mk(0, 0, 0, 1, 1, 8'd1, 3'd1, 8'h69, 8'h00, 8'h69, 8'h69, 4'b1101);
    run_frame("hold1", hv, 37);
    hv = mk(0, 0, 0, 1, 1, 8'd1, 3'd1, 8'h96, 8'h00, 8'h96, 8'h96, 4'b1101);
    run_frame("hold2", hv, 35);
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    chk("release", "cs_n", 32'(cs_n), 32'hF);

    // Out-of-range select with a second start while busy.
    hv = mk(0, 0, 0, 0, 1, 8'd1, 3'd7, 8'h3C, 8'h00, 8'h3C, 8'h3C, 4'b1111);
    setup_inputs(hv);
    start = 1'b1;
    n = 0; dones = 0; cs_bad = 0;
    repeat (100) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 5) begin start = 1'b1; data_in = 8'hFF; cs_sel = 3'd0; end
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) chk("busy", "frame length", 32'(n), 32'd37);
      end
      if (cs_n !== 4'hF) cs_bad++;
    end
    chk("busy", "done count", 32'(dones), 32'd1);
    chk("busy", "cs_n samples low", 32'(cs_bad), 32'd0);
    chk("busy", "data_out", 32'(data_out), 32'h3C);

    // Asynchronous reset in the middle of the transfer, away from any clk edge.
    hv = mk(1, 1, 0, 0, 1, 8'd1, 3'd2, 8'hA5, 8'h00, 8'hA5, 8'hA5, 4'b1011);
    setup_inputs(hv);
    prev = sck; edges = 0; n = 0;
    start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (sck !== prev) edges++;
      prev = sck;
    end while (edges < 5 && n < 200);
    chk("midreset", "reached edge 5", 32'(edges), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("midreset", "sck", 32'(sck), 32'd0);
    chk("midreset", "cs_n", 32'(cs_n), 32'hF);
    chk("midreset", "busy", 32'(busy), 32'd0);
    chk("midreset", "mosi", 32'(mosi), 32'd0);
    chk("midreset", "data_out", 32'(data_out), 32'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    rst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("midreset", "no done", 32'(dones), 32'd0);
    chk("midreset", "idle after", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
